// File: rtl/mult_arb_if.sv
// Bundle of requester, multiplier and result signals for the two-requester multiplier arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mult_arb_if #(
    parameter int TAG_W = 4
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [23:0]      req0_a;
    logic [23:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [23:0]      req1_a;
    logic [23:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic [23:0]      mul_a;
    logic [23:0]      mul_b;
    logic             mul_start;
    logic [47:0]      mul_prod;

    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_prod;
    logic             res_id;
    logic [TAG_W-1:0] res_tag;

    logic [3:0]       inflight;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_tag,
        input  mul_prod, res_ready,
        output req0_ready, req1_ready,
        output mul_a, mul_b, mul_start,
        output res_valid, res_prod, res_id, res_tag,
        output inflight, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        output req1_valid, req1_a, req1_b, req1_tag,
        output mul_prod, res_ready,
        input  req0_ready, req1_ready,
        input  mul_a, mul_b, mul_start,
        input  res_valid, res_prod, res_id, res_tag,
        input  inflight, busy
    );
endinterface

// File: rtl/mult_arb.sv
// Round-robin arbiter feeding an external PIPE_LAT-stage 24x24 multiplier; a slot
// tracker mirrors each multiplier stage so the final product carries its requester id and tag.
module mult_arb #(
    parameter int TAG_W    = 4,
    parameter int PIPE_LAT = 5
) (
    input  logic          clk,
    input  logic          rst,
    mult_arb_if.slave     bus
);

    logic [PIPE_LAT-1:0] r_slot_vld;
    logic                r_slot_id  [PIPE_LAT];
    logic [TAG_W-1:0]    r_slot_tag [PIPE_LAT];
    logic                r_last;
    logic [3:0]          r_inflight;

    logic                w_res_valid;
    logic                w_adv;
    logic                w_gnt_vld;
    logic                w_gnt_id;
    logic [TAG_W-1:0]    w_gnt_tag;
    logic                w_res_hs;

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        w_res_valid = r_slot_vld[PIPE_LAT-1] && !rst;
        w_adv       = !w_res_valid || bus.res_ready;
        w_gnt_vld   = 1'b0;
        w_gnt_id    = 1'b0;
        if (!rst && w_adv) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_last;
            end else if (bus.req0_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end else if (bus.req1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
        end
        w_gnt_tag = w_gnt_id ? bus.req1_tag : bus.req0_tag;
        w_res_hs  = w_res_valid && bus.res_ready;
    end

    assign bus.req0_ready = w_gnt_vld && !w_gnt_id;
    assign bus.req1_ready = w_gnt_vld &&  w_gnt_id;
    assign bus.mul_a      = !w_gnt_vld ? '0 : (w_gnt_id ? bus.req1_a : bus.req0_a);
    assign bus.mul_b      = !w_gnt_vld ? '0 : (w_gnt_id ? bus.req1_b : bus.req0_b);
    assign bus.mul_start  = w_adv;
    assign bus.res_valid  = w_res_valid;
    assign bus.res_prod   = bus.mul_prod;
    assign bus.res_id     = r_slot_id[PIPE_LAT-1];
    assign bus.res_tag    = r_slot_tag[PIPE_LAT-1];
    assign bus.inflight   = rst ? 4'd0 : r_inflight;
    assign bus.busy       = !rst && (r_inflight != 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_vld <= '0;
            r_last     <= 1'b1;
            r_inflight <= 4'd0;
        end else begin
            if (w_adv) begin
                r_slot_vld[0] <= w_gnt_vld;
                for (int k = PIPE_LAT - 1; k > 0; k--) begin
                    r_slot_vld[k] <= r_slot_vld[k-1];
                end
            end
            if (w_gnt_vld) begin
                r_last <= w_gnt_id;
            end
            if (w_gnt_vld && !w_res_hs) begin
                r_inflight <= r_inflight + 4'd1;
            end else if (!w_gnt_vld && w_res_hs) begin
                r_inflight <= r_inflight - 4'd1;
            end
        end
    end

    // NOTE: id/tag storage is not reset; the slot valids alone decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_slot_id[0]  <= w_gnt_id;
            r_slot_tag[0] <= w_gnt_tag;
            for (int k = PIPE_LAT - 1; k > 0; k--) begin
                r_slot_id[k]  <= r_slot_id[k-1];
                r_slot_tag[k] <= r_slot_tag[k-1];
            end
        end
    end

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 Parameter TAG_W, default 4, width of the requester-supplied tag carried alongside each operation.
REQ-002 Parameter PIPE_LAT, default 5, number of start-enabled clock edges from operand capture to product at the 24x24 pipelined multiplier output; legal range 1-8.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Ports (name direction width meaning), one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  24  requester 0 operands
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid, req1_ready, req1_a, req1_b, req1_tag  as requester 0, for requester 1
- mul_a, mul_b  out  24  multiplier operands
- mul_start  out  1  multiplier pipeline advance enable
- mul_prod  in  48  multiplier final-stage product
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_prod  out  48  product
- res_id  out  1  requester index of the result
- res_tag  out  TAG_W  tag of the result
- inflight  out  4  operations in the pipeline
- busy  out  1  inflight != 0

Function
REQ-005 Pipeline tracker: PIPE_LAT slots, each holding valid, id and tag; slot k mirrors multiplier stage k.
REQ-006 advance = !res_valid || res_ready; mul_start SHALL equal advance (combinational).
REQ-007 On a clock edge with advance=1: slot1 <= issued op (valid=issue), slot k <= slot k-1; advance=0: all slots hold.
REQ-008 res_valid = slot PIPE_LAT valid; res_id/res_tag from that slot; res_prod = mul_prod.
REQ-009 Grant only when advance=1; reqX_ready = advance && grant==X; issue = req0_ready&&req0_valid || req1_ready&&req1_valid.
REQ-010 Arbitration: one valid requester wins; both valid -> requester not served last wins (round robin); last-served pointer updates only on issue; pointer resets to 1 (requester 0 wins first tie).
REQ-011 mul_a/mul_b: granted requester operands; no grant -> zero (bubble, slot1 valid=0).
REQ-012 Latency: operation accepted in cycle N with res_ready held high appears with res_valid=1 in cycle N+PIPE_LAT.
REQ-013 Throughput: one accept per cycle while res_ready=1; results emerge in accept order.
REQ-014 Backpressure: res_valid=1 && res_ready=0 -> mul_start=0, both ready=0, res_prod/res_id/res_tag stable until handshake.
REQ-015 Simultaneous result handshake and new accept in same cycle are both legal and both take effect.
REQ-016 inflight = count of valid slots; increments on issue, decrements on result handshake, unchanged when both; never exceeds PIPE_LAT.
REQ-017 Requester obligation: operands and tag stable while valid=1 and ready=0; the block does not check it.

Reset
REQ-018 rst=1 at a clock edge clears all slot valids, sets pointer to 1, inflight=0.
REQ-019 Outputs during/after reset: res_valid=0, busy=0, inflight=0, mul_start=1, req ready per REQ-009 (gated by rst=0: both ready=0 while rst=1).
REQ-020 Reset mid-operation discards in-flight operations; no result for them is ever produced; stale multiplier contents are masked by slot valids.

Verification
REQ-021 Single op: req0 a=3 b=5 tag=2, res_ready=1 -> res_valid in cycle N+5 with prod=15, id=0, tag=2, then inflight=0.
REQ-022 Tie: both valid continuously (req0 a=1 b=1, req1 a=2 b=2) -> grants 0,1,0,1...; results 1,4,1,4 with alternating id.
REQ-023 Backpressure: 3 back-to-back ops, res_ready=0 from first res_valid for 4 cycles -> outputs held, mul_start=0, inflight=3, no loss/reorder after release.
REQ-024 Max operands: a=b=24'hFFFFFF -> prod=48'hFFFFFE000001.
REQ-025 Reset mid-flight: 4 ops issued, rst pulsed 1 cycle -> res_valid stays 0 for next 8 cycles, inflight=0, next op returns correct result at N+5.
REQ-026 Full stream with simultaneous accept and handshake every cycle for 20 cycles -> inflight constant 5, 20 correct in-order results.
